// File: rtl/fu_scheduler.sv
// rtl/fu_scheduler.sv - FU readiness / writeback-slot scheduler with CSR serialisation.
// Optional FU_SCHED_PERF_EN adds per-class stall counters (perf_stall, perf_clr).
module fu_scheduler #(
  parameter int iwd    = 2,
  parameter int ewd    = 2,
  parameter int mullat = 3,
  parameter int divlat = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_ready,
  input  logic [iwd-1:0]               iss_valid,
  input  logic [iwd-1:0][4:0]          iss_fu,
  output logic [iwd-1:0]               issue,
  output logic [4:0]                   fu_ready,
  input  logic                         red_valid,
  input  logic                         red_div_kill,
`ifdef FU_SCHED_PERF_EN
  input  logic                         perf_clr,
  output logic [4:0][31:0]             perf_stall,
`endif
  output logic [$clog2(divlat)+2:0]    inflight
);

  localparam int CW      = $clog2(ewd + 1);
  localparam int TW      = $clog2(divlat + 1);
  localparam int DCW     = $clog2(divlat);
  localparam int IFW     = $clog2(divlat) + 3;
  localparam int MUL_CHK = (mullat < divlat) ? mullat + 1 : divlat;
  localparam logic [CW-1:0] EWD_C = CW'(ewd);

  logic [CW-1:0]  rsv   [1:divlat];
  logic [CW-1:0]  rsv_n [1:divlat];
  logic [DCW-1:0] divcnt, divcnt_n;
  logic [IFW-1:0] inflight_n, ngrant;
  logic [4:0]     ready_n;
  logic [TW-1:0]  tgt;
  logic           ok, any_g, div_g, mem_g, csr_g;

  // rsv_n starts as the shifted state and doubles as the running copy for lane-ordered grants.
  always_comb begin
    for (int d = 1; d < divlat; d++) rsv_n[d] = rsv[d+1];
    rsv_n[divlat] = '0;
    issue  = '0;
    ngrant = '0;
    any_g  = 1'b0;
    div_g  = 1'b0;
    mem_g  = 1'b0;
    csr_g  = 1'b0;
    tgt    = '0;
    ok     = 1'b0;
    for (int i = 0; i < iwd; i++) begin
      tgt = '0;
      ok  = 1'b0;
      if (iss_fu[i][0]) begin
        tgt = TW'(1);
        ok  = fu_ready[0];
      end else if (iss_fu[i][1]) begin
        ok  = fu_ready[1] && mem_ready && !mem_g;
      end else if (iss_fu[i][2]) begin
        tgt = TW'(mullat);
        ok  = fu_ready[2];
      end else if (iss_fu[i][3]) begin
        tgt = TW'(divlat);
        ok  = fu_ready[3] && (divcnt == '0) && !div_g;
      end else if (iss_fu[i][4]) begin
        tgt = TW'(1);
        ok  = fu_ready[4] && (inflight == '0) && !any_g && (i == 0);
      end
      if (tgt != '0 && rsv_n[tgt] >= EWD_C) ok = 1'b0;
      if (rst || red_valid || csr_g || !iss_valid[i]) ok = 1'b0;
      if (ok) begin
        issue[i] = 1'b1;
        any_g    = 1'b1;
        if (tgt != '0) begin
          rsv_n[tgt] = rsv_n[tgt] + CW'(1);
          ngrant     = ngrant + IFW'(1);
        end
        mem_g = mem_g | iss_fu[i][1];
        div_g = div_g | iss_fu[i][3];
        csr_g = csr_g | iss_fu[i][4];
      end
    end
  end

  always_comb begin
    inflight_n = inflight + ngrant - IFW'(rsv[1]);
    if (div_g)                          divcnt_n = DCW'(divlat - 1);
    else if (red_valid && red_div_kill) divcnt_n = '0;
    else if (divcnt != '0)              divcnt_n = divcnt - DCW'(1);
    else                                divcnt_n = divcnt;
    ready_n[0] = rsv_n[2] < EWD_C;
    ready_n[1] = mem_ready;
    ready_n[2] = rsv_n[MUL_CHK] < EWD_C;
    ready_n[3] = (divcnt_n == '0) && (rsv_n[divlat] < EWD_C);
    ready_n[4] = inflight_n == '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 1; d <= divlat; d++) rsv[d] <= '0;
      divcnt   <= '0;
      inflight <= '0;
      fu_ready <= 5'b11101;
    end else begin
      for (int d = 1; d <= divlat; d++) rsv[d] <= rsv_n[d];
      divcnt   <= divcnt_n;
      inflight <= inflight_n;
      fu_ready <= ready_n;
    end
  end

`ifdef FU_SCHED_PERF_EN
  logic [4:0] stall;

  always_comb begin
    stall = '0;
    for (int i = 0; i < iwd; i++)
      for (int k = 0; k < 5; k++)
        if (iss_valid[i] && iss_fu[i][k] && !issue[i]) stall[k] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_stall <= '0;
    end else begin
      for (int k = 0; k < 5; k++)
        if (stall[k] && perf_stall[k] != '1) perf_stall[k] <= perf_stall[k] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_scheduler.sv
// tb/tb_fu_scheduler.sv - self-checking bench for fu_scheduler (default build).
module tb_fu_scheduler;

  localparam logic [4:0] ALU = 5'b00001;
  localparam logic [4:0] MEM = 5'b00010;
  localparam logic [4:0] MUL = 5'b00100;
  localparam logic [4:0] DIV = 5'b01000;
  localparam logic [4:0] CSR = 5'b10000;

  logic            clk = 1'b0;
  logic            rst, mem_ready, red_valid, red_div_kill;
  logic [1:0]      iss_valid, issue;
  logic [1:0][4:0] iss_fu;
  logic [4:0]      fu_ready;
  logic [6:0]      inflight;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] v;
    logic [4:0] f0, f1;
    logic       mr, rv;
    logic [1:0] iss;
    logic [6:0] infl;
    logic [4:0] rdy;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  fu_scheduler dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .iss_valid(iss_valid), .iss_fu(iss_fu),
    .issue(issue), .fu_ready(fu_ready), .red_valid(red_valid), .red_div_kill(red_div_kill),
    .inflight(inflight)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle (entered at posedge+1), checks issue mid-cycle, returns at next posedge+1.
  task automatic drive(input string name, input logic [1:0] v, input logic [4:0] f0,
                       input logic [4:0] f1, input logic mr, input logic rv, input logic rk,
                       input logic [1:0] exp);
    iss_valid = v; iss_fu[0] = f0; iss_fu[1] = f1;
    mem_ready = mr; red_valid = rv; red_div_kill = rk;
    exp_q.push_back(exp);
    #2;
    check(name, 32'(issue), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    iss_valid = '0; mem_ready = 1'b1; red_valid = 1'b0; red_div_kill = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    vecs[0]  = '{2'b11, ALU, ALU, 1'b1, 1'b0, 2'b11, 7'd2, 5'b01111};
    vecs[1]  = '{2'b11, MEM, ALU, 1'b0, 1'b0, 2'b10, 7'd1, 5'b01101};
    vecs[2]  = '{2'b11, MEM, MEM, 1'b1, 1'b0, 2'b01, 7'd0, 5'b11111};
    vecs[3]  = '{2'b11, DIV, DIV, 1'b1, 1'b0, 2'b01, 7'd1, 5'b00111};
    vecs[4]  = '{2'b11, CSR, ALU, 1'b1, 1'b0, 2'b01, 7'd1, 5'b01111};
    vecs[5]  = '{2'b10, ALU, CSR, 1'b1, 1'b0, 2'b00, 7'd0, 5'b11111};
    vecs[6]  = '{2'b11, ALU, CSR, 1'b1, 1'b0, 2'b01, 7'd1, 5'b01111};
    vecs[7]  = '{2'b11, MUL, MUL, 1'b1, 1'b0, 2'b11, 7'd2, 5'b01111};
    vecs[8]  = '{2'b00, ALU, ALU, 1'b1, 1'b0, 2'b00, 7'd0, 5'b11111};
    vecs[9]  = '{2'b11, MUL, DIV, 1'b1, 1'b0, 2'b11, 7'd2, 5'b00111};
    vecs[10] = '{2'b01, CSR, ALU, 1'b1, 1'b0, 2'b01, 7'd1, 5'b01111};
    vecs[11] = '{2'b11, ALU, ALU, 1'b1, 1'b1, 2'b00, 7'd0, 5'b11111};
    vecs[12] = '{2'b11, DIV, MUL, 1'b1, 1'b0, 2'b11, 7'd2, 5'b00111};
    vecs[13] = '{2'b11, MEM, DIV, 1'b1, 1'b0, 2'b11, 7'd1, 5'b00111};

    rst = 1'b1; mem_ready = 1'b1; red_valid = 1'b0; red_div_kill = 1'b0;
    iss_valid = '0; iss_fu = '0;
    repeat (2) @(posedge clk);
    #1;
    iss_valid = 2'b11; iss_fu[0] = ALU; iss_fu[1] = ALU;
    #1;
    check("rst_issue", 32'(issue), 32'd0);
    iss_valid = '0; rst = 1'b0;
    #1;
    check("rst_fu_ready", 32'(fu_ready), 32'b11101);
    check("rst_inflight", 32'(inflight), 32'd0);
    @(posedge clk); #1;
    check("post_rst_fu_ready", 32'(fu_ready), 32'b11111);

    foreach (vecs[i]) begin
      drive($sformatf("vec%0d_issue", i), vecs[i].v, vecs[i].f0, vecs[i].f1,
            vecs[i].mr, vecs[i].rv, vecs[i].rv, vecs[i].iss);
      check($sformatf("vec%0d_inflight", i), 32'(inflight), 32'(vecs[i].infl));
      check($sformatf("vec%0d_fu_ready", i), 32'(fu_ready), 32'(vecs[i].rdy));
      idle(20);
      check($sformatf("vec%0d_drained", i), 32'(inflight), 32'd0);
    end

    // ALU pair: written back one cycle after landing.
    drive("alu_pair", 2'b11, ALU, ALU, 1'b1, 1'b0, 1'b0, 2'b11);
    check("alu_pair_ready", 32'(fu_ready[0]), 32'd1);
    check("alu_pair_infl2", 32'(inflight), 32'd2);
    idle(1);
    check("alu_pair_infl0", 32'(inflight), 32'd0);
    idle(3);

    // Divider occupancy window and re-grant alongside the first writeback.
    drive("div_t0", 2'b01, DIV, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("div_busy_t%0d", k), 32'(fu_ready[3]), 32'd0);
      if (k == 8) drive("div_t8_denied", 2'b01, DIV, ALU, 1'b1, 1'b0, 1'b0, 2'b00);
      else        idle(1);
    end
    check("div_ready_t16", 32'(fu_ready[3]), 32'd1);
    check("div_infl_t16", 32'(inflight), 32'd1);
    drive("div_regrant_t16", 2'b11, DIV, ALU, 1'b1, 1'b0, 1'b0, 2'b11);
    check("div_wb_t17", 32'(inflight), 32'd2);
    idle(20);

    // Writeback port conflict: MUL landing in the same slot as an ALU pair.
    drive("mul_t0", 2'b01, MUL, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    idle(1);
    check("conf_alu_ready", 32'(fu_ready[0]), 32'd1);
    drive("conf_alu_pair", 2'b11, ALU, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    check("conf_infl", 32'(inflight), 32'd2);
    idle(8);

    // CSR waits for in-flight MUL, then blocks the younger lane.
    drive("csr_mul", 2'b01, MUL, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    for (int k = 1; k <= 3; k++)
      drive($sformatf("csr_wait%0d", k), 2'b01, CSR, ALU, 1'b1, 1'b0, 1'b0, 2'b00);
    check("csr_infl0", 32'(inflight), 32'd0);
    check("csr_ready", 32'(fu_ready[4]), 32'd1);
    drive("csr_grant", 2'b11, CSR, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    check("csr_infl1", 32'(inflight), 32'd1);
    idle(4);

    // Redirect with divide kill frees the divider while its slot drains.
    drive("kill_div_t0", 2'b01, DIV, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    idle(3);
    check("kill_busy_t4", 32'(fu_ready[3]), 32'd0);
    drive("kill_redirect", 2'b11, ALU, ALU, 1'b1, 1'b1, 1'b1, 2'b00);
    check("kill_ready_t5", 32'(fu_ready[3]), 32'd1);
    check("kill_infl_t5", 32'(inflight), 32'd1);
    drive("kill_regrant", 2'b01, DIV, ALU, 1'b1, 1'b0, 1'b0, 2'b01);
    check("kill_infl_t6", 32'(inflight), 32'd2);
    idle(20);
    check("final_drained", 32'(inflight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
